// File: rtl/vram_dma_if.sv
// Bus bundle between the copy engine, main-memory read port and VRAM write port.
// master = the DMA engine, slave = memory/VRAM side.
interface vram_dma_if #(
  parameter int VRAM_ADDR_W = 9
);
  logic [31:0]            mem_addr;
  logic                   mem_req;
  logic                   mem_ready;
  logic [31:0]            mem_rdata;
  logic [VRAM_ADDR_W-1:0] vram_addr;
  logic [7:0]             vram_wdata;
  logic                   vram_wenable;

  modport master (
    output mem_addr, mem_req, vram_addr, vram_wdata, vram_wenable,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_addr, mem_req, vram_addr, vram_wdata, vram_wenable,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/vram_dma.sv
// Byte copy engine from main memory into tile-map VRAM, with optional vblank-gated start.
// Optional constant-fill mode is compiled in with VRAM_DMA_FILL_EN.
module vram_dma #(
  parameter int VRAM_ADDR_W = 9,
  parameter int LEN_W       = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  input  logic        reg_wenable,
  output logic [31:0] reg_rdata,
  input  logic        v_sync,
  output logic        irq,
  vram_dma_if.master  bus
);

  typedef enum logic [1:0] {IDLE, WAIT_VB, READ, WRITE} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            src_q;
  logic [VRAM_ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]       len_q;
  logic [7:0]             byte_q;
  logic [7:0]             fill_val_q;
  logic                   wait_vb_q;
  logic                   irq_q;
  logic                   abort_q;
  logic                   fill_q;
  logic                   fill_start;

  logic ctrl_wr, start_req, ack_req, abort_req, abort_any;
  logic busy, handshake, done;
  logic [7:0] sel_byte;

  assign ctrl_wr   = reg_wenable && (reg_addr == 2'd3);
  assign start_req = ctrl_wr && reg_wdata[0];
  assign ack_req   = ctrl_wr && reg_wdata[4];
  assign abort_req = ctrl_wr && reg_wdata[5];
  assign abort_any = abort_q || abort_req;
  assign busy      = (state_q != IDLE);
  assign handshake = (state_q == READ) && bus.mem_ready;

`ifdef VRAM_DMA_FILL_EN
  logic fill_mode_q;
  assign fill_q     = fill_mode_q;
  assign fill_start = reg_wdata[3];
`else
  assign fill_q     = 1'b0;
  assign fill_start = 1'b0;
`endif

  // Little-endian lane select: address bits [1:0] pick the byte in the word.
  always_comb begin
    case (src_q[1:0])
      2'd0:    sel_byte = bus.mem_rdata[7:0];
      2'd1:    sel_byte = bus.mem_rdata[15:8];
      2'd2:    sel_byte = bus.mem_rdata[23:16];
      default: sel_byte = bus.mem_rdata[31:24];
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_req) begin
          if (len_q == '0)       done    = 1'b1;
          else if (reg_wdata[2]) state_d = WAIT_VB;
          else                   state_d = fill_start ? WRITE : READ;
        end
      end
      WAIT_VB: begin
        if (abort_req)   state_d = IDLE;
        else if (!v_sync) state_d = fill_q ? WRITE : READ;
      end
      READ: begin
        if (handshake) state_d = abort_any ? IDLE : WRITE;
      end
      WRITE: begin
        if (len_q == LEN_W'(1)) begin
          state_d = IDLE;
          done    = !abort_any;
        end else if (abort_any) begin
          state_d = IDLE;
        end else begin
          state_d = fill_q ? WRITE : READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      byte_q     <= '0;
      fill_val_q <= '0;
      wait_vb_q  <= 1'b0;
      irq_q      <= 1'b0;
      abort_q    <= 1'b0;
`ifdef VRAM_DMA_FILL_EN
      fill_mode_q <= 1'b0;
`endif
    end else begin
      // Configuration is frozen while a transfer is running.
      if (reg_wenable && !busy) begin
        case (reg_addr)
          2'd0: src_q <= reg_wdata;
          2'd1: dst_q <= reg_wdata[VRAM_ADDR_W-1:0];
          2'd2: len_q <= reg_wdata[LEN_W-1:0];
          default: begin
            wait_vb_q  <= reg_wdata[2];
            fill_val_q <= reg_wdata[15:8];
`ifdef VRAM_DMA_FILL_EN
            fill_mode_q <= reg_wdata[3];
`endif
          end
        endcase
      end

      if (state_d == IDLE)       abort_q <= 1'b0;
      else if (abort_req && busy) abort_q <= 1'b1;

      if (handshake) byte_q <= sel_byte;

      if (state_q == WRITE) begin
        dst_q <= dst_q + VRAM_ADDR_W'(1);
        len_q <= len_q - LEN_W'(1);
        if (!fill_q) src_q <= src_q + 32'd1;
      end

      // A completion on the same cycle as an ack leaves irq set.
      if (done)         irq_q <= 1'b1;
      else if (ack_req) irq_q <= 1'b0;
    end
  end

  assign bus.mem_req      = (state_q == READ);
  assign bus.mem_addr     = src_q;
  assign bus.vram_wenable = (state_q == WRITE);
  assign bus.vram_addr    = dst_q;
  assign bus.vram_wdata   = fill_q ? fill_val_q : byte_q;
  assign irq              = irq_q;

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      2'd0: reg_rdata = src_q;
      2'd1: reg_rdata[VRAM_ADDR_W-1:0] = dst_q;
      2'd2: reg_rdata[LEN_W-1:0] = len_q;
      default: begin
        reg_rdata[1]    = busy;
        reg_rdata[2]    = wait_vb_q;
        reg_rdata[3]    = fill_q;
        reg_rdata[4]    = irq_q;
        reg_rdata[15:8] = fill_val_q;
      end
    endcase
  end

endmodule

// File: doc/vram_dma.md
Name: vram_dma

Overview:
- Copy engine directly upstream of the 800x600 tile video unit.
- The CPU programs a source byte address in main memory, a destination VRAM byte address and a length.
- The engine reads bytes over a req/ready memory port and writes them one at a time into the video unit's VRAM write port, so tile maps load without CPU byte loops.
- An optional vblank gate delays the start until v_sync is low, which avoids mid-frame tearing.

Parameters:
- VRAM_ADDR_W, 9, VRAM byte-address width (512-byte tile map); the destination address wraps modulo 2^VRAM_ADDR_W.
- LEN_W, 10, width of the length / remaining-count register.

Ports:
- clk  in  1  system clock; the single clock domain.
- rst_n  in  1  reset: synchronous, active-low.
- reg_addr  in  2  register select: 0 SRC, 1 DST, 2 LEN, 3 CTRL.
- reg_wdata  in  32  register write data.
- reg_wenable  in  1  register write strobe.
- reg_rdata  out  32  combinational read of the selected register.
- mem_addr  out  32  byte address of the current read.
- mem_req  out  1  read request.
- mem_ready  in  1  read completes on a cycle where mem_req && mem_ready.
- mem_rdata  in  32  word read data; the byte is selected by mem_addr[1:0] (little-endian lane).
- v_sync  in  1  the video unit's v_sync (active low).
- vram_addr  out  VRAM_ADDR_W  VRAM write address.
- vram_wdata  out  8  VRAM write byte.
- vram_wenable  out  1  one-cycle VRAM write strobe.
- irq  out  1  done flag, level; stays high until acknowledged.

Behaviour:
- Reset values: mem_req=0, vram_wenable=0, irq=0, all outputs 0, state IDLE, all registers 0.
- Reset is taken on the clk edge when rst_n=0, including mid-transfer. A partially written VRAM is left as is, and mem_req drops at that edge.
- Register writes:
  - SRC takes [31:0]; DST takes [VRAM_ADDR_W-1:0]; LEN takes [LEN_W-1:0].
  - Writes to SRC, DST or LEN while busy are ignored.
- CTRL write bits:
  - bit0 start.
  - bit2 wait_vblank.
  - bit4 ack: writing 1 clears irq.
  - bit5 abort.
  - [15:8] fill value (used by the optional feature).
- CTRL read bits: bit1 busy, bit2 wait_vblank, bit3 fill_mode, bit4 done (=irq), [15:8] fill value. The start, ack and abort bits read as 0.
- Reads of SRC, DST and LEN return the live counters, so LEN reads the remaining byte count.
- State IDLE: on a CTRL write with start=1:
  - LEN==0: irq<=1 next cycle, stay IDLE, no memory or VRAM activity.
  - Otherwise go to WAIT_VB if wait_vblank=1, else READ.
  - A start while not IDLE is ignored.
- State WAIT_VB: go to READ on the first cycle v_sync==0 is sampled.
- State READ:
  - mem_req=1 with mem_addr=SRC; both are held stable until mem_ready.
  - On the handshake cycle, latch the byte and go to WRITE.
- State WRITE:
  - vram_wenable=1 for exactly one cycle, with vram_addr=DST and vram_wdata=the latched byte.
  - Then SRC+=1, DST+=1 (wraps modulo 2^VRAM_ADDR_W), LEN-=1.
  - If the new LEN==0: go to IDLE and irq<=1. Otherwise go to READ.
- Throughput: 2 cycles per byte when mem_ready is held high.
- Abort:
  - In WAIT_VB, go to IDLE next cycle.
  - In READ, the in-flight request completes (mem_req stays high until mem_ready), then go to IDLE with no VRAM write.
  - In WRITE, the current write completes, then go to IDLE.
  - Abort never sets irq. Counters keep their partial values.
- Simultaneous done and ack on the same cycle: irq ends set (done wins).
- SRC increments modulo 2^32.

Optional Feature:
- Macro: VRAM_DMA_FILL_EN.
- When defined:
  - CTRL bit3 is writable as fill_mode.
  - With fill_mode=1 the engine skips READ (no mem_req) and each WRITE stores CTRL[15:8]. Throughput is 1 byte per cycle. SRC is unchanged.
- When undefined:
  - CTRL bit3 writes are ignored and read 0.
  - Fill logic is absent; the engine always copies.

Test Plan:
- SRC=0x100, DST=0x010, LEN=4, mem_ready held 1, memory bytes 0xA0..0xA3 -> VRAM writes (0x010,A0), (0x011,A1), (0x012,A2), (0x013,A3), one every 2 cycles. Then irq=1, busy=0, LEN reads 0.
- DST=0x1FE, LEN=3 -> writes at 0x1FE, 0x1FF, 0x000 (wrap). Unaligned SRC=0x203 selects mem_rdata[31:24] for the first byte.
- mem_ready stalled 5 cycles -> mem_addr and mem_req stay stable, with no vram_wenable until the handshake. Abort issued during the stall -> the read completes, then IDLE, no write, irq=0.
- wait_vblank=1 with v_sync=1 for 20 cycles -> no mem_req. v_sync=0 -> the first mem_req appears the following cycle.
- LEN=0 start -> irq=1 next cycle, zero writes. Ack write -> irq=0. A start while busy plus a DST write while busy -> both ignored.
- With VRAM_DMA_FILL_EN: fill_mode=1, fill value 0x3C, DST=0, LEN=504 -> 504 consecutive single-cycle writes of 0x3C and mem_req never asserted. rst_n=0 at byte 100 -> outputs cleared at that edge.
